// File: rtl/apb_requester_pkg.sv
// Shared types and widths for the APB requester and its command FIFO.
package apb_requester_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;

    // Requester bus phases.
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    // One queued transfer request.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Two-entry command FIFO with synchronous active-low reset.
// Pushes while full and pops while empty are ignored.
module apb_cmd_fifo
    import apb_requester_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  cmd_t data_i,
    input  logic pop_i,
    output cmd_t data_o,
    output logic full_o,
    output logic empty_o
);

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       do_push, do_pop;
    cmd_t       mem_q [FIFO_DEPTH];

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Next occupancy and pointer values.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = ~wr_ptr_q;
        if (do_pop)  rd_ptr_d = ~rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Occupancy and pointer registers.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_ni) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage written on accepted pushes.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; the count decides which entries are valid.
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/apb_requester.sv
// APB requester: buffers commands, runs SETUP/ACCESS transfers with a
// wait-state timeout, and returns a one-cycle response pulse per transfer.
module apb_requester
    import apb_requester_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              RSP_TIMEOUT,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e            state_q, state_d;
    logic [7:0]        wait_q, wait_d;
    logic [7:0]        wait_inc;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    cmd_t fifo_in, fifo_head;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign fifo_in   = '{write: CMD_WRITE, addr: CMD_ADDR, wdata: CMD_WDATA};
    assign CMD_READY = !fifo_full;
    assign fifo_push = CMD_VALID && CMD_READY;

    apb_cmd_fifo u_cmd_fifo (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wait_inc = wait_q + 8'd1;

    // Transfer sequencing, command pop/load and response generation.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        fifo_pop      = 1'b0;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    pwrite_d = fifo_head.write;
                    paddr_d  = fifo_head.addr;
                    pwdata_d = fifo_head.wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                wait_d  = 8'd0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    // Completion wins even on the cycle the timeout would fire.
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    wait_d      = 8'd0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        pwrite_d = fifo_head.write;
                        paddr_d  = fifo_head.addr;
                        pwdata_d = fifo_head.wdata;
                        state_d  = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wait_inc == TIMEOUT_LIMIT) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    wait_d        = 8'd0;
                    state_d       = IDLE;
                end else begin
                    wait_d = wait_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, bus-control and response registers.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            wait_q        <= 8'd0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign PSELx       = (state_q != IDLE);
    assign PENABLE     = (state_q == ACCESS);
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_ERR     = rsp_err_q;
    assign RSP_TIMEOUT = rsp_timeout_q;
    assign RSP_RDATA   = rsp_rdata_q;

endmodule
